// File: rtl/vga_fb_reader_if.sv
// ---------------------------------------------------------------------------
// vga_fb_reader_if
// Framebuffer read bus between the VGA scan-out reader and the framebuffer.
//   rd_en   : read strobe, one pixel per clk while inside the fetch window
//   rd_x    : 9-bit read column
//   rd_y    : 9-bit read row
//   rd_data : 12-bit RGB pixel, returned a fixed RD_LAT cycles after rd_en
// master = reader (drives the request), slave = framebuffer (returns data).
// ---------------------------------------------------------------------------
interface vga_fb_reader_if;
   logic        rd_en;
   logic [8:0]  rd_x;
   logic [8:0]  rd_y;
   logic [11:0] rd_data;

   modport master (output rd_en, output rd_x, output rd_y, input rd_data);
   modport slave  (input rd_en, input rd_x, input rd_y, output rd_data);
endinterface

// File: rtl/vga_fb_reader.sv
// ---------------------------------------------------------------------------
// vga_fb_reader
// Scans the 12-bit RGB timer framebuffer in raster order and produces VGA
// timing (default 640x480@60) with sync, blanking and pixel data aligned.
// Ports:
//   clk         : pixel clock, all logic on the rising edge
//   reset       : synchronous, active-high
//   fb          : framebuffer read bus (master side: rd_en/rd_x/rd_y out,
//                 rd_data in, rd_data valid RD_LAT cycles after rd_en)
//   hsync/vsync : active-low sync
//   rgb         : {R,G,B} 4 bits each, 0 outside the active region
//   de          : active-video flag aligned with rgb
//   vblank      : high while the output line is in vertical blank
//   frame_start : one-cycle pulse with output pixel (0,0)
// Every output trails the counters by RD_LAT+2 cycles.
// ---------------------------------------------------------------------------
module vga_fb_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int FB_W     = 512,
   parameter int RD_LAT   = 1
) (
   input  logic            clk,
   input  logic            reset,
   vga_fb_reader_if.master fb,
   output logic            hsync,
   output logic            vsync,
   output logic [11:0]     rgb,
   output logic            de,
   output logic            vblank,
   output logic            frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // Flags travel RD_LAT+1 stages: one for the request register, RD_LAT for the memory.
   localparam int DLY     = RD_LAT + 1;

   localparam logic [9:0]  H_MAX  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_MAX  = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [10:0] FB_LIM = 11'(FB_W);

   // Flag vector layout {fs, vb, vs_n, hs_n, fetch, active}
   localparam int F_ACT   = 0;
   localparam int F_FETCH = 1;
   localparam int F_HS    = 2;
   localparam int F_VS    = 3;
   localparam int F_VB    = 4;
   localparam int F_FS    = 5;
   localparam logic [5:0] FLAGS_IDLE = 6'b00_1100;   // syncs released, all else low

   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic        rd_en_q;
   logic [8:0]  rd_x_q, rd_y_q;
   logic [5:0]  flags_s;
   logic [5:0]  flag_pipe_q [DLY];
   logic [5:0]  flags_out_s;
   logic [11:0] rgb_q;
   logic        de_q, hsync_q, vsync_q, vblank_q, frame_start_q;

   // Raster counter next state: h wraps every line, v advances on h wrap
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_MAX) begin
         h_cnt_d = 10'd0;
         if (v_cnt_q == V_MAX) begin
            v_cnt_d = 10'd0;
         end else begin
            v_cnt_d = v_cnt_q + 10'd1;
         end
      end else begin
         h_cnt_d = h_cnt_q + 10'd1;
      end
   end

   // Counter-stage decode of the current raster position
   always_comb begin
      flags_s           = FLAGS_IDLE;
      flags_s[F_ACT]    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      flags_s[F_FETCH]  = flags_s[F_ACT] && ({1'b0, h_cnt_q} < FB_LIM);
      flags_s[F_HS]     = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
      flags_s[F_VS]     = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
      flags_s[F_VB]     = (v_cnt_q >= V_ACT);
      flags_s[F_FS]     = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
   end

   // Raster counters and framebuffer request register
   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt_q <= 10'd0;
         v_cnt_q <= 10'd0;
         rd_en_q <= 1'b0;
         rd_x_q  <= 9'd0;
         rd_y_q  <= 9'd0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         rd_en_q <= flags_s[F_FETCH];
         // Address tracks the counters even outside the window; only rd_en gates it
         rd_x_q  <= h_cnt_q[8:0];
         rd_y_q  <= v_cnt_q[8:0];
      end
   end

   // Flag delay line so timing flags meet rd_data at the output stage
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DLY; i++) begin
            flag_pipe_q[i] <= FLAGS_IDLE;
         end
      end else begin
         flag_pipe_q[0] <= flags_s;
         for (int i = 1; i < DLY; i++) begin
            flag_pipe_q[i] <= flag_pipe_q[i-1];
         end
      end
   end

   assign flags_out_s = flag_pipe_q[DLY-1];

   // Output register: pixel data is taken only when the delayed fetch flag is set
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_q         <= 12'h000;
         de_q          <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         vblank_q      <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         rgb_q         <= (flags_out_s[F_FETCH] && flags_out_s[F_ACT]) ? fb.rd_data : 12'h000;
         de_q          <= flags_out_s[F_ACT];
         hsync_q       <= flags_out_s[F_HS];
         vsync_q       <= flags_out_s[F_VS];
         vblank_q      <= flags_out_s[F_VB];
         frame_start_q <= flags_out_s[F_FS];
      end
   end

   assign fb.rd_en    = rd_en_q;
   assign fb.rd_x     = rd_x_q;
   assign fb.rd_y     = rd_y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign rgb         = rgb_q;
   assign de          = de_q;
   assign vblank      = vblank_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_reader
// Two instances: A at full 640x480 timing with RD_LAT=1, B with a shrunken
// raster (25x10 total, 16x6 active, FB_W=12) and RD_LAT=3 so whole frames
// fit in a short run. Each framebuffer model returns {x[5:0],y[5:0]} for a
// strobed read and 12'hFFF otherwise. Every cycle both instances are compared
// against a position-based model; directed checks cover latency, sync edges,
// window edge pixels and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_vga_fb_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   vga_fb_reader_if fa ();
   vga_fb_reader_if fbb ();
   logic        hs_a, vs_a, de_a, vb_a, fs_a;
   logic [11:0] rgb_a;
   logic        hs_b, vs_b, de_b, vb_b, fs_b;
   logic [11:0] rgb_b;

   vga_fb_reader #(.RD_LAT(1)) u_dut_a (
      .clk(clk), .reset(rst_a), .fb(fa),
      .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a), .de(de_a),
      .vblank(vb_a), .frame_start(fs_a)
   );

   vga_fb_reader #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .FB_W(12), .RD_LAT(3)
   ) u_dut_b (
      .clk(clk), .reset(rst_b), .fb(fbb),
      .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b), .de(de_b),
      .vblank(vb_b), .frame_start(fs_b)
   );

   // Framebuffer model A: one-cycle read latency
   always @(posedge clk) begin
      fa.rd_data <= fa.rd_en ? {fa.rd_x[5:0], fa.rd_y[5:0]} : 12'hFFF;
   end

   // Framebuffer model B: three-cycle read latency
   logic [11:0] b_p1, b_p2;
   always @(posedge clk) begin
      b_p1        <= fbb.rd_en ? {fbb.rd_x[5:0], fbb.rd_y[5:0]} : 12'hFFF;
      b_p2        <= b_p1;
      fbb.rd_data <= b_p2;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Expected {rd_en, rd_x, rd_y, rgb, de, hsync, vsync, vblank, frame_start}
   // e = clock edges since the last edge that sampled reset high.
   function automatic logic [35:0] exp_vec(input int e, input int lat,
         input int ha, input int hfp, input int hsw, input int hbp,
         input int va, input int vfp, input int vsw, input int vbp, input int fbw);
      int ht, vt, d, p, h, v;
      logic       q_en;
      logic [8:0] q_x, q_y;
      logic [11:0] o_rgb;
      logic o_de, o_hs, o_vs, o_vb, o_fs;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      d  = lat + 2;
      q_en = 1'b0; q_x = 9'd0; q_y = 9'd0;
      o_rgb = 12'h000; o_de = 1'b0; o_hs = 1'b1; o_vs = 1'b1; o_vb = 1'b0; o_fs = 1'b0;
      if (e >= 1) begin
         p = e - 1; h = p % ht; v = (p / ht) % vt;
         q_en = (h < ha) && (v < va) && (h < fbw);
         q_x  = h[8:0];
         q_y  = v[8:0];
      end
      if (e >= d) begin
         p = e - d; h = p % ht; v = (p / ht) % vt;
         o_de  = (h < ha) && (v < va);
         o_rgb = (o_de && (h < fbw)) ? {h[5:0], v[5:0]} : 12'h000;
         o_hs  = !((h >= ha + hfp) && (h < ha + hfp + hsw));
         o_vs  = !((v >= va + vfp) && (v < va + vfp + vsw));
         o_vb  = (v >= va);
         o_fs  = (h == 0) && (v == 0);
      end
      return {q_en, q_x, q_y, o_rgb, o_de, o_hs, o_vs, o_vb, o_fs};
   endfunction

   int   cyc = 0;
   int   e_a = 0, e_b = 0;
   bit   chk_on = 1'b0;
   logic hs_prev_a = 1'b1, vs_prev_b = 1'b1;
   int   q_fs_a[$], q_hsf_a[$], q_fs_b[$], q_vsf_b[$];
   int   de_cnt_a, hs_lo_a, vs_lo_b, vb_hi_b;

   task automatic clear_mon();
      q_fs_a.delete(); q_hsf_a.delete(); q_fs_b.delete(); q_vsf_b.delete();
      de_cnt_a = 0; hs_lo_a = 0; vs_lo_b = 0; vb_hi_b = 0;
   endtask

   // Advance n clocks; sample on the falling edge, run the per-cycle model and monitors
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         e_a = rst_a ? 0 : e_a + 1;
         e_b = rst_b ? 0 : e_b + 1;
         @(negedge clk);
         cyc++;
         if (chk_on) begin
            check("stream_A", 64'({fa.rd_en, fa.rd_x, fa.rd_y, rgb_a, de_a, hs_a, vs_a, vb_a, fs_a}),
                  64'(exp_vec(e_a, 1, 640, 16, 96, 48, 480, 10, 2, 33, 512)));
            check("stream_B", 64'({fbb.rd_en, fbb.rd_x, fbb.rd_y, rgb_b, de_b, hs_b, vs_b, vb_b, fs_b}),
                  64'(exp_vec(e_b, 3, 16, 2, 4, 3, 6, 1, 2, 1, 12)));
         end
         if (fs_a === 1'b1) q_fs_a.push_back(cyc);
         if (hs_prev_a === 1'b1 && hs_a === 1'b0) q_hsf_a.push_back(cyc);
         if (de_a === 1'b1) de_cnt_a++;
         if (hs_a === 1'b0) hs_lo_a++;
         if (fs_b === 1'b1) q_fs_b.push_back(cyc);
         if (vs_prev_b === 1'b1 && vs_b === 1'b0) q_vsf_b.push_back(cyc);
         if (vs_b === 1'b0) vs_lo_b++;
         if (vb_b === 1'b1) vb_hi_b++;
         hs_prev_a = hs_a;
         vs_prev_b = vs_b;
      end
   endtask

   int rel;

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      run(3);
      chk_on = 1'b1;

      // Let counters move, then hold reset for 5 cycles
      rst_a = 1'b0; rst_b = 1'b0;
      run(40);
      rst_a = 1'b1; rst_b = 1'b1;
      run(5);
      check("reset_A", 64'({fa.rd_en, fa.rd_x, fa.rd_y, rgb_a, de_a, hs_a, vs_a, vb_a, fs_a}), 64'd12);
      check("reset_B", 64'({fbb.rd_en, fbb.rd_x, fbb.rd_y, rgb_b, de_b, hs_b, vs_b, vb_b, fs_b}), 64'd12);

      // Run three full A lines (and ~9.6 B frames) from a clean release
      clear_mon();
      rel = cyc;
      rst_a = 1'b0; rst_b = 1'b0;
      run(58);
      check("B_pix_3_2", 64'({de_b, rgb_b}), 64'h10C2);
      run(10);
      check("B_pix_13_2_beyond_fb", 64'({de_b, rgb_b}), 64'h1000);
      run(740);
      check("A_pix_5_1", 64'({de_a, rgb_a}), 64'h1141);
      run(506);
      check("A_pix_511_1", 64'({de_a, rgb_a}), 64'h1FC1);
      run(1);
      check("A_pix_512_1_beyond_fb", 64'({de_a, rgb_a}), 64'h1000);
      check("A_rden_col514", 64'(fa.rd_en), 64'd0);
      check("A_rdx_col514", 64'(fa.rd_x), 64'd2);
      run(1087);

      check("A_fs_latency", 64'(q_fs_a[0] - rel), 64'd3);
      check("B_fs_latency", 64'(q_fs_b[0] - rel), 64'd5);
      check("A_hs_falls", 64'(q_hsf_a.size()), 64'd3);
      check("A_hs_fall_col", 64'(q_hsf_a[0] - q_fs_a[0]), 64'd656);
      check("A_hs_period", 64'(q_hsf_a[1] - q_hsf_a[0]), 64'd800);
      check("A_hs_low_cycles", 64'(hs_lo_a), 64'd288);
      check("A_de_cycles", 64'(de_cnt_a), 64'd1920);
      check("B_fs_count", 64'(q_fs_b.size()), 64'd10);
      check("B_fs_period", 64'(q_fs_b[1] - q_fs_b[0]), 64'd250);
      check("B_vs_fall_line7", 64'(q_vsf_b[0] - q_fs_b[0]), 64'd175);
      check("B_vs_low_cycles", 64'(vs_lo_b), 64'd450);
      check("B_vblank_cycles", 64'(vb_hi_b), 64'd900);

      // Mid-frame reset: A at (282,2), B at (7,5)
      rst_a = 1'b1; rst_b = 1'b1;
      run(2);
      rst_a = 1'b0; rst_b = 1'b0;
      run(1882);
      rst_a = 1'b1; rst_b = 1'b1;
      run(1);
      check("A_midreset_next_edge", 64'({fa.rd_en, fa.rd_x, fa.rd_y, rgb_a, de_a, hs_a, vs_a, vb_a, fs_a}), 64'd12);
      check("B_midreset_next_edge", 64'({fbb.rd_en, fbb.rd_x, fbb.rd_y, rgb_b, de_b, hs_b, vs_b, vb_b, fs_b}), 64'd12);
      run(1);
      clear_mon();
      rel = cyc;
      rst_a = 1'b0; rst_b = 1'b0;
      run(900);
      check("A_fs_after_midreset", 64'(q_fs_a[0] - rel), 64'd3);
      check("B_fs_after_midreset", 64'(q_fs_b[0] - rel), 64'd5);
      check("A_first_hs_fall_after_midreset", 64'(q_hsf_a[0] - rel), 64'd659);
      check("A_hs_low_after_midreset", 64'(hs_lo_a), 64'd96);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
